// File: rtl/misao_mem_arbiter.sv
// Memory port arbiter for the MISA-O system: the core has priority, a starvation counter
// forces an occasional debug slot, and halt mode hands the port exclusively to debug.
module misao_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_wait,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              d_halt,
    output logic              d_halted,
    output logic              m_en_rd,
    output logic              m_en_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {RUN, FORCE, HALT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] starve_cnt, cnt_next;
    logic          c_any, core_grant, debug_grant;

    // Grants are suppressed while rst is high so no strobe reaches memory in that cycle.
    always_comb begin
        c_any       = c_rd | c_wr;
        core_grant  = 1'b0;
        debug_grant = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    core_grant  = c_any;
                    debug_grant = !c_any && d_req;
                end
                FORCE: begin
                    debug_grant = d_req;
                    core_grant  = !d_req && c_any;
                end
                HALT:    debug_grant = d_req;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        c_rdata  = '0;
        d_rdata  = '0;
        d_ack    = debug_grant;
        c_wait   = !rst && c_any && !core_grant;
        d_halted = !rst && (state == HALT);
        m_en_rd  = 1'b0;
        m_en_wr  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        if (core_grant) begin
            m_en_wr = c_wr;
            m_en_rd = c_rd && !c_wr;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            c_rdata = m_rdata;
        end else if (debug_grant) begin
            m_en_wr = d_we;
            m_en_rd = !d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            if (!d_we) d_rdata = m_rdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = starve_cnt;
        if (debug_grant || !d_req)
            cnt_next = '0;
        else if (state == RUN && starve_cnt != CNT_MAX)
            cnt_next = starve_cnt + 1'b1;

        if (d_halt) begin
            state_next = HALT;
        end else begin
            case (state)
                HALT: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
                RUN: if (cnt_next == CNT_MAX) state_next = FORCE;
                FORCE: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
        end
    end
endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Directed bench for misao_mem_arbiter: a small memory model answers the m_* port and
// each scenario task compares outputs against hand-computed values.
module tb_misao_mem_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              c_rd, c_wr, d_req, d_we, d_halt;
    logic [ADDR_W-1:0] c_addr, d_addr, m_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata, c_rdata, d_rdata, m_wdata, m_rdata;
    logic              c_wait, d_ack, d_halted, m_en_rd, m_en_wr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255] = '{default: 8'h00};

    always #5 clk = ~clk;

    assign m_rdata = m_en_rd ? mem[m_addr[7:0]] : 8'h00;
    always @(posedge clk) if (m_en_wr) mem[m_addr[7:0]] <= m_wdata;

    misao_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_wait(c_wait),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_halt(d_halt), .d_halted(d_halted),
        .m_en_rd(m_en_rd), .m_en_wr(m_en_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_halt = 0;
    endtask

    task automatic test_reset;
        rst = 1; idle_inputs();
        c_rd = 1; c_addr = 15'd3; d_req = 1; d_we = 1; d_addr = 15'd9; d_wdata = 8'h11;
        #2;
        n_checks++;
        if ({m_en_rd, m_en_wr, m_addr, m_wdata, c_wait, d_ack, d_halted, c_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en_rd=%b en_wr=%b addr=%0d wait=%b ack=%b halted=%b, required all 0",
                     m_en_rd, m_en_wr, m_addr, c_wait, d_ack, d_halted);
        end
        next_cycle();
        n_checks++;
        if (mem[9] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_write: mem[9]=%h required 00", mem[9]);
        end
        idle_inputs();
        rst = 0;
        next_cycle();
    endtask

    task automatic load_mem;
        d_req = 1; d_we = 1; d_addr = 15'd3; d_wdata = 8'h45;
        next_cycle();
        d_addr = 15'd7; d_wdata = 8'hA7;
        next_cycle();
        idle_inputs();
        n_checks++;
        if (mem[3] !== 8'h45 || mem[7] !== 8'hA7) begin
            n_fail++;
            $display("FAIL debug_preload: mem[3]=%h mem[7]=%h required 45 A7", mem[3], mem[7]);
        end
    endtask

    task automatic test_core_only;
        c_rd = 1; c_addr = 15'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (m_en_rd !== 1'b1 || m_en_wr !== 1'b0 || m_addr !== 15'd3 || c_rdata !== 8'h45 ||
                c_wait !== 1'b0 || d_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL core_only[%0d]: en_rd=%b en_wr=%b addr=%0d rdata=%h wait=%b ack=%b, required 1 0 3 45 0 0",
                         i, m_en_rd, m_en_wr, m_addr, c_rdata, c_wait, d_ack);
            end
            next_cycle();
            n_checks++;
            if (dut.starve_cnt !== '0) begin
                n_fail++;
                $display("FAIL core_only_starve[%0d]: starve_cnt=%0d required 0", i, dut.starve_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_contention;
        bit dbg;
        c_rd = 1; c_addr = 15'd3; d_req = 1; d_we = 0; d_addr = 15'd7;
        for (int i = 0; i < 10; i++) begin
            dbg = (i == 4) || (i == 9);
            #1;
            n_checks++;
            if (d_ack !== dbg || c_wait !== dbg || c_rdata !== (dbg ? 8'h00 : 8'h45) ||
                d_rdata !== (dbg ? 8'hA7 : 8'h00) || m_addr !== (dbg ? 15'd7 : 15'd3)) begin
                n_fail++;
                $display("FAIL contention[%0d]: ack=%b wait=%b c_rdata=%h d_rdata=%h addr=%0d, debug slot required=%b",
                         i, d_ack, c_wait, c_rdata, d_rdata, m_addr, dbg);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_halt;
        c_rd = 1; c_addr = 15'd3; d_halt = 1;
        #1;
        n_checks++;
        if (c_wait !== 1'b0 || d_halted !== 1'b0 || c_rdata !== 8'h45) begin
            n_fail++;
            $display("FAIL halt_enter_cycle: wait=%b halted=%b rdata=%h required 0 0 45", c_wait, d_halted, c_rdata);
        end
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 15'd10; d_wdata = 8'h5A;
        #1;
        n_checks++;
        if (d_halted !== 1'b1 || c_wait !== 1'b1 || d_ack !== 1'b1 || m_en_wr !== 1'b1 ||
            m_en_rd !== 1'b0 || m_addr !== 15'd10 || m_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL halt_debug_write: halted=%b wait=%b ack=%b en_wr=%b en_rd=%b addr=%0d wdata=%h, required 1 1 1 1 0 10 5a",
                     d_halted, c_wait, d_ack, m_en_wr, m_en_rd, m_addr, m_wdata);
        end
        next_cycle();
        d_req = 0; d_we = 0;
        n_checks++;
        if (mem[10] !== 8'h5A || c_wait !== 1'b1 || d_halted !== 1'b1 || m_en_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_hold: mem[10]=%h wait=%b halted=%b en_rd=%b required 5a 1 1 0",
                     mem[10], c_wait, d_halted, m_en_rd);
        end
        next_cycle();
        d_halt = 0;
        #1;
        n_checks++;
        if (c_wait !== 1'b1 || d_halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_exit_cycle: wait=%b halted=%b required 1 1", c_wait, d_halted);
        end
        next_cycle();
        n_checks++;
        if (c_wait !== 1'b0 || d_halted !== 1'b0 || c_rdata !== 8'h45) begin
            n_fail++;
            $display("FAIL halt_resume: wait=%b halted=%b rdata=%h required 0 0 45", c_wait, d_halted, c_rdata);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_core_rd_wr;
        c_rd = 1; c_wr = 1; c_addr = 15'd20; c_wdata = 8'h3C;
        #1;
        n_checks++;
        if (m_en_wr !== 1'b1 || m_en_rd !== 1'b0 || m_addr !== 15'd20 || m_wdata !== 8'h3C || c_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL core_rd_wr: en_wr=%b en_rd=%b addr=%0d wdata=%h wait=%b required 1 0 20 3c 0",
                     m_en_wr, m_en_rd, m_addr, m_wdata, c_wait);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (mem[20] !== 8'h3C) begin
            n_fail++;
            $display("FAIL core_rd_wr_mem: mem[20]=%h required 3c", mem[20]);
        end
    endtask

    task automatic check_rst_cycle(input string tag);
        #1;
        n_checks++;
        if ({m_en_rd, m_en_wr, m_addr, m_wdata, d_ack, c_wait, d_halted} !== '0) begin
            n_fail++;
            $display("FAIL %s_rst_cycle: en_rd=%b en_wr=%b addr=%0d ack=%b wait=%b halted=%b required all 0",
                     tag, m_en_rd, m_en_wr, m_addr, d_ack, c_wait, d_halted);
        end
        next_cycle();
        rst = 0;
        #1;
        n_checks++;
        if (d_halted !== 1'b0 || c_wait !== 1'b0 || d_ack !== 1'b0 || m_en_rd !== 1'b1 || m_addr !== 15'd3) begin
            n_fail++;
            $display("FAIL %s_after_rst: halted=%b wait=%b ack=%b en_rd=%b addr=%0d required 0 0 0 1 3",
                     tag, d_halted, c_wait, d_ack, m_en_rd, m_addr);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_halt;
        d_halt = 1;
        next_cycle();
        n_checks++;
        if (d_halted !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_halt_entry: halted=%b required 1", d_halted);
        end
        rst = 1; d_halt = 0;
        c_rd = 1; c_addr = 15'd3; d_req = 1; d_we = 1; d_addr = 15'd30; d_wdata = 8'hFF;
        check_rst_cycle("mid_halt");
        n_checks++;
        if (mem[30] !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_halt_no_write: mem[30]=%h required 00", mem[30]);
        end
    endtask

    task automatic test_reset_mid_force;
        c_rd = 1; c_addr = 15'd3; d_req = 1; d_we = 0; d_addr = 15'd7;
        for (int i = 0; i < 4; i++) next_cycle();
        rst = 1;
        check_rst_cycle("mid_force");
    endtask

    task automatic test_debug_alone;
        d_req = 1; d_we = 0; d_addr = 15'd7;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (d_ack !== 1'b1 || d_rdata !== 8'hA7 || m_en_rd !== 1'b1 || m_addr !== 15'd7 ||
                c_wait !== 1'b0 || d_halted !== 1'b0) begin
                n_fail++;
                $display("FAIL debug_alone[%0d]: ack=%b rdata=%h en_rd=%b addr=%0d wait=%b halted=%b required 1 a7 1 7 0 0",
                         i, d_ack, d_rdata, m_en_rd, m_addr, c_wait, d_halted);
            end
            next_cycle();
            n_checks++;
            if (dut.starve_cnt !== '0 || d_halted !== 1'b0) begin
                n_fail++;
                $display("FAIL debug_alone_state[%0d]: starve_cnt=%0d halted=%b required 0 0", i, dut.starve_cnt, d_halted);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        load_mem();
        test_core_only();
        test_contention();
        test_halt();
        test_core_rd_wr();
        test_reset_mid_halt();
        test_reset_mid_force();
        test_debug_alone();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
